instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Field-to-word instruction packer: the inverse of the field splitter in the decode stage.
//  Accepts decoded fields plus a format tag, packs them into a 32-bit MIPS word, and buffers
//  the words in a small FIFO. Emits each word with a sequential instruction-memory address.
//  Feeds the IM write/preload port and the self-check harness.
// PARAMETERS
//  DEPTH      4             FIFO entries; power of two, >=2
//  BASE_ADDR  32'h0000_3000 address given to the first word after reset or flush
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; clears FIFO, count, address and flags
//  flush      in   1   synchronous clear of FIFO and address counter
//  in_valid   in   1   field set is valid this cycle
//  in_ready   out  1   encoder can accept; = (count < DEPTH)
//  fmt        in   2   0=R, 1=I, 2=J, 3=illegal
//  opcode     in   6   instr[31:26]
//  rs         in   5   instr[25:21] for R/I
//  rt         in   5   instr[20:16] for R/I
//  rd         in   5   instr[15:11] for R
//  sa         in   5   instr[10:6] for R
//  func       in   6   instr[5:0] for R
//  imm16      in   16  instr[15:0] for I
//  imm26      in   26  instr[25:0] for J
//  out_valid  out  1   head word is valid; = (count != 0)
//  out_ready  in   1   consumer takes the head word
//  out_instr  out  32  head word; 32'h0 when empty
//  out_addr   out  32  address of head word
//  count      out  $clog2(DEPTH)+1  current occupancy
//  fmt_err    out  1   one-cycle pulse: an illegal fmt was accepted
// BEHAVIOUR
//  Reset values: count=0, out_valid=0, out_instr=0, out_addr=BASE_ADDR, fmt_err=0, in_ready=1.
//  Push:
//   - Occurs when in_valid && in_ready.
//   - Fields not used by fmt are ignored.
//  Encoding:
//   - R = {opcode,rs,rt,rd,sa,func}
//   - I = {opcode,rs,rt,imm16}
//   - J = {opcode,imm26}
//  fmt=3 handshake: consumed (in_ready honoured), not enqueued, fmt_err=1 on the next cycle only.
//  Pop: occurs when out_valid && out_ready. out_addr += 4 on each pop, wrapping mod 2^32.
//  Latency: a word pushed into an empty FIFO shows on out_* the cycle after the push.
//   No combinational in->out path.
//  Stability: out_instr/out_addr hold while out_valid && !out_ready.
//  Simultaneous push+pop:
//   - Allowed when 0 < count < DEPTH; count unchanged.
//   - When full, in_ready=0, so only the pop happens; in_ready rises the next cycle.
//   - When empty, only the push happens (no bypass).
//  Order: strict FIFO; read/write pointers wrap modulo DEPTH.
//  flush:
//   - Next edge: count=0, pointers=0, out_addr=BASE_ADDR.
//   - Beats any push/pop in the same cycle; those handshakes are discarded and fmt_err is not raised.
//  reset:
//   - Takes effect immediately mid-stream; buffered words are lost.
//   - Outputs return to reset values without a clock.
//  No overflow/underflow is possible by construction; count never exceeds DEPTH.
// TESTING
//  1. R push op=0,rs=1,rt=2,rd=3,sa=0,func=6'h21, out_ready=1
//     -> next cycle out_instr=32'h0022_1821, out_addr=32'h3000
//  2. Then I op=6'h0d,rs=0,rt=1,imm16=16'h1234 -> out_instr=32'h3401_1234, out_addr=32'h3004
//  3. J op=6'h02,imm26=26'h0000C00 -> out_instr=32'h0800_0C00; fields rs/rd ignored
//  4. out_ready=0, push 5 words -> in_ready=0 after 4, count=4, 5th not taken; head unchanged.
//     Then one pop+push cycle -> count stays 4, order preserved.
//  5. fmt=3 push -> fmt_err high exactly 1 cycle, count unchanged, out_addr unchanged
//  6. With 3 buffered words, assert reset asynchronously (no clk edge)
//     -> count=0, out_valid=0, out_instr=0 at once; the next word gets out_addr=32'h3000.
//     Repeat with flush + simultaneous push -> FIFO empty.

Source files
------------

// File: rtl/instr_encoder.sv
// Field-to-word MIPS instruction packer with a small output FIFO.
// Each popped word carries a sequential instruction-memory address starting at BASE_ADDR.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [5:0]               opcode,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               sa,
  input  logic [5:0]               func,
  input  logic [15:0]              imm16,
  input  logic [25:0]              imm26,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fmt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_ILL = 2'd3
  } fmt_e;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_addr;
  logic          r_fmt_err;

  logic [31:0]   w_word;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  assign in_ready  = (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign out_addr  = r_addr;
  assign fmt_err   = r_fmt_err;
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign out_instr = out_valid ? r_mem[r_rd_ptr] : 32'h0;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && (fmt != FMT_ILL);
  assign w_pop    = out_valid && out_ready;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_word = 32'h0;
    case (fmt)
      FMT_R:   w_word = {opcode, rs, rt, rd, sa, func};
      FMT_I:   w_word = {opcode, rs, rt, imm16};
      FMT_J:   w_word = {opcode, imm26};
      default: w_word = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_addr    <= BASE_ADDR;
      r_fmt_err <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_addr    <= BASE_ADDR;
      r_fmt_err <= 1'b0;
    end else begin
      r_fmt_err <= w_accept && (fmt == FMT_ILL);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_addr   <= r_addr + 32'd4;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the word array carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= w_word;
  end

endmodule
